// File: rtl/wb_trace_streamer_if.sv
// Writeback tap, trace-record stream and status bundle for wb_trace_streamer.
// master drives the WB tap, control and trc_ready; slave is the streamer. trc_seq exists only under WB_TRACE_SEQ_EN.
interface wb_trace_streamer_if #(
    parameter int DATA_W = 64,
    parameter int CNT_W  = 5
);
    logic              trc_en;
    logic              trc_clear;
    logic              wb_valid;
    logic [4:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [DATA_W-1:0] wb_pc;
    logic              trc_valid;
    logic              trc_ready;
    logic [4:0]        trc_rd;
    logic [DATA_W-1:0] trc_data;
    logic [DATA_W-1:0] trc_pc;
    logic [CNT_W-1:0]  trc_count;
    logic              trc_overflow;
    logic [15:0]       trc_drop_cnt;
`ifdef WB_TRACE_SEQ_EN
    logic [15:0]       trc_seq;
`endif

    modport master (
`ifdef WB_TRACE_SEQ_EN
        input  trc_seq,
`endif
        output trc_en, trc_clear, wb_valid, wb_rd, wb_data, wb_pc, trc_ready,
        input  trc_valid, trc_rd, trc_data, trc_pc, trc_count, trc_overflow, trc_drop_cnt
    );

    modport slave (
`ifdef WB_TRACE_SEQ_EN
        output trc_seq,
`endif
        input  trc_en, trc_clear, wb_valid, wb_rd, wb_data, wb_pc, trc_ready,
        output trc_valid, trc_rd, trc_data, trc_pc, trc_count, trc_overflow, trc_drop_cnt
    );
endinterface

// File: rtl/wb_trace_streamer.sv
// Captures retired register writes into a FWFT trace FIFO; a record is visible one cycle after capture, held while trc_ready is low.
// Pushes into a full FIFO without a same-cycle pop are dropped and counted; WB_TRACE_SEQ_EN adds a per-record sequence number.
module wb_trace_streamer #(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 64,
    parameter bit FILTER_XZR = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    wb_trace_streamer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
`ifdef WB_TRACE_SEQ_EN
        logic [15:0]       seq;
`endif
        logic [4:0]        rd;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] pc;
    } rec_t;

    typedef enum logic {IDLE, STREAM} state_t;

    state_t        state_q, state_d;
    rec_t          mem_q [DEPTH];
    rec_t          wr_rec;
    rec_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   drop_q, drop_d;
    logic          push_req, pop, full, push_ok, drop, trc_vld;
`ifdef WB_TRACE_SEQ_EN
    logic [15:0]   seq_q, seq_d;
`endif

    assign push_req = bus.wb_valid & bus.trc_en & ~(FILTER_XZR & (bus.wb_rd == 5'd31));
    assign trc_vld  = (state_q == STREAM);
    assign pop      = trc_vld & bus.trc_ready;
    assign full     = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign push_ok  = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_comb begin
        wr_rec      = '0;
        wr_rec.rd   = bus.wb_rd;
        wr_rec.data = bus.wb_data;
        wr_rec.pc   = bus.wb_pc;
`ifdef WB_TRACE_SEQ_EN
        wr_rec.seq  = seq_q;
`endif
    end

    always_comb begin
        state_d = state_q;
        if (bus.trc_clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (push_ok) state_d = STREAM;
                STREAM:  if (pop && !push_ok && count_q == CW'(1)) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;
        if (bus.trc_clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            ovf_d    = 1'b0;
            drop_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
        end
    end

`ifdef WB_TRACE_SEQ_EN
    // Dropped pushes still consume a number so the consumer can see gaps.
    always_comb begin
        seq_d = seq_q;
        if (bus.trc_clear)  seq_d = '0;
        else if (push_req)  seq_d = seq_q + 16'd1;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
`ifdef WB_TRACE_SEQ_EN
            seq_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
`ifdef WB_TRACE_SEQ_EN
            seq_q    <= seq_d;
`endif
        end
    end

    // Storage needs no reset: the head is only exposed while state is STREAM.
    always_ff @(posedge clk_i) begin
        if (push_ok && !bus.trc_clear) mem_q[wr_ptr_q] <= wr_rec;
    end

    assign head             = mem_q[rd_ptr_q];
    assign bus.trc_valid    = trc_vld;
    assign bus.trc_rd       = trc_vld ? head.rd   : '0;
    assign bus.trc_data     = trc_vld ? head.data : '0;
    assign bus.trc_pc       = trc_vld ? head.pc   : '0;
    assign bus.trc_count    = count_q;
    assign bus.trc_overflow = ovf_q;
    assign bus.trc_drop_cnt = drop_q;
`ifdef WB_TRACE_SEQ_EN
    assign bus.trc_seq      = trc_vld ? head.seq  : '0;
`endif
endmodule
